// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: instruction/PC widths, reset PC and fetch FSM encodings.
package cpu_defs_pkg;

  localparam int unsigned InstW   = 37;
  localparam int unsigned PcW     = 8;
  localparam int unsigned ResetPc = 0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, instruction} between the ROM response and decode.
// Head outputs read as zero while the buffer is empty.
module fetch_buf
  import cpu_defs_pkg::*;
#(
  parameter int unsigned DataW = InstW,
  parameter int unsigned AddrW = PcW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [AddrW-1:0] push_pc_i,
  input  logic [DataW-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic             head_valid_o,
  output logic [AddrW-1:0] head_pc_o,
  output logic [DataW-1:0] head_data_o
);

  logic [AddrW-1:0] pc_q   [2];
  logic [DataW-1:0] data_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // Pointer and occupancy update; flush overrides any push/pop.
  always_comb begin
    do_pop   = pop_i & (count_q != 2'd0);
    do_push  = push_i & ((count_q != 2'd2) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (do_push && !flush_i) begin
      pc_q[wr_ptr_q]   <= push_pc_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Head view toward decode.
  always_comb begin
    count_o      = count_q;
    head_valid_o = (count_q != 2'd0);
    head_pc_o    = head_valid_o ? pc_q[rd_ptr_q] : '0;
    head_data_o  = head_valid_o ? data_q[rd_ptr_q] : '0;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues ROM reads, buffers responses, hands {pc, inst} to decode.
// Optional FETCH_STATS_EN adds saturating handshake and stall counters.
module inst_fetch
  import cpu_defs_pkg::*;
#(
  parameter int unsigned DataW   = InstW,
  parameter int unsigned AddrW   = PcW,
  parameter int unsigned ResetPcP = ResetPc
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             halt_req_i,
  input  logic             redirect_valid_i,
  input  logic [AddrW-1:0] redirect_pc_i,
  output logic             rom_read_o,
  output logic             rom_enable_o,
  output logic [AddrW-1:0] rom_address_o,
  input  logic [DataW-1:0] rom_dout_i,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  output logic [DataW-1:0] inst_data_o,
  output logic [AddrW-1:0] inst_pc_o,
`ifdef FETCH_STATS_EN
  output logic [15:0]      fetch_count_o,
  output logic [15:0]      stall_count_o,
`endif
  output logic             busy_o
);

  fetch_state_e     state_q, state_d;
  logic [AddrW-1:0] pc_q, pc_d;
  logic [AddrW-1:0] issue_pc_q;
  logic             inflight_q;
  logic [1:0]       count;
  logic             pop, push, issue;
  logic [2:0]       occ_after;

  // A pop this cycle frees a slot, which keeps back-to-back issue going at 1/cycle.
  assign pop       = inst_valid_o & inst_ready_i;
  assign push      = inflight_q & ~redirect_valid_i;
  assign occ_after = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = (state_q == StRun) & ~halt_req_i & ~redirect_valid_i & (occ_after < 3'd2);

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state; halt_req beats start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i && !halt_req_i) state_d = StRun;
      StRun:    if (halt_req_i) state_d = StHalted;
      StHalted: if (start_i && !halt_req_i) state_d = StRun;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs: ROM strobes and busy.
  always_comb begin
    rom_read_o    = issue;
    rom_enable_o  = issue;
    rom_address_o = pc_q;
    busy_o        = (state_q == StRun) | inflight_q | (count != 2'd0);
  end

  // PC next state; redirect takes priority over sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) pc_d = redirect_pc_i;
    else if (issue)       pc_d = pc_q + 1'b1;
  end

  // PC, in-flight flag and the address tag of the in-flight request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= AddrW'(ResetPcP);
      inflight_q <= 1'b0;
      issue_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) issue_pc_q <= pc_q;
    end
  end

  fetch_buf #(
    .DataW (DataW),
    .AddrW (AddrW)
  ) u_fetch_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (redirect_valid_i),
    .push_i       (push),
    .push_pc_i    (issue_pc_q),
    .push_data_i  (rom_dout_i),
    .pop_i        (pop),
    .count_o      (count),
    .head_valid_o (inst_valid_o),
    .head_pc_o    (inst_pc_o),
    .head_data_o  (inst_data_o)
  );

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, stall_cnt_q;

  // Saturating handshake and stall counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (inst_valid_o && !inst_ready_i && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign fetch_count_o = fetch_cnt_q;
  assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch with a registered 1-cycle ROM model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, redirect_valid, inst_ready;
  logic [7:0]  redirect_pc;
  logic        rom_read, rom_enable, inst_valid, busy;
  logic [7:0]  rom_address, inst_pc;
  logic [36:0] rom_dout = '0;
  logic [36:0] inst_data;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count, stall_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int nreq;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .halt_req_i       (halt_req),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .rom_read_o       (rom_read),
    .rom_enable_o     (rom_enable),
    .rom_address_o    (rom_address),
    .rom_dout_i       (rom_dout),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .inst_data_o      (inst_data),
    .inst_pc_o        (inst_pc),
`ifdef FETCH_STATS_EN
    .fetch_count_o    (fetch_count),
    .stall_count_o    (stall_count),
`endif
    .busy_o           (busy)
  );

  // ROM model: mem[i] = 37'h10_0000_0000 | i, registered read.
  always @(posedge clk) begin
    if (rom_read && rom_enable) rom_dout <= 37'h10_0000_0000 | {29'd0, rom_address};
  end

  function automatic logic [36:0] memv(input logic [7:0] a);
    return 37'h10_0000_0000 | {29'd0, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 8'h00; inst_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_rom_read", rom_read, 0);
    chk("rst_rom_enable", rom_enable, 0);
    chk("rst_rom_address", rom_address, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_busy", busy, 0);

    // 1. Streaming fetch with decode always ready.
    start = 1'b1; inst_ready = 1'b1; #1;
    chk("t1_idle_no_read", rom_read, 0);
    tick(); start = 1'b0; #1;
    chk("t1_read0", rom_read, 1);
    chk("t1_addr0", rom_address, 8'h00);
    chk("t1_valid_s1", inst_valid, 0);
    tick(); #1;
    chk("t1_addr1", rom_address, 8'h01);
    chk("t1_valid_s2", inst_valid, 0);
    tick(); #1;
    chk("t1_valid_s3", inst_valid, 1);
    chk("t1_pc0", inst_pc, 8'h00);
    chk("t1_data0", inst_data, memv(8'h00));
    chk("t1_addr2", rom_address, 8'h02);
    tick(); #1;
    chk("t1_pc1", inst_pc, 8'h01);
    chk("t1_data1", inst_data, memv(8'h01));
    tick(); #1;
    chk("t1_pc2", inst_pc, 8'h02);
`ifdef FETCH_STATS_EN
    chk("t1_fetch_count", fetch_count, 2);
`endif

    // 2. Decode stalled for 10 cycles: only two requests, head stable.
    do_reset();
    start = 1'b1; inst_ready = 1'b0;
    tick(); start = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rom_read) nreq++;
      tick();
    end
    #1;
    chk("t2_req_count", nreq, 2);
    chk("t2_valid", inst_valid, 1);
    chk("t2_pc0_held", inst_pc, 8'h00);
    chk("t2_data0_held", inst_data, memv(8'h00));
    chk("t2_busy", busy, 1);
`ifdef FETCH_STATS_EN
    chk("t2_stall_count", stall_count, 8);
    chk("t2_fetch_count", fetch_count, 0);
`endif
    inst_ready = 1'b1; #1;
    chk("t2_reissue", rom_read, 1);
    chk("t2_reissue_addr", rom_address, 8'h02);
    tick(); #1;
    chk("t2_pc1", inst_pc, 8'h01);
    tick(); #1;
    chk("t2_pc2_no_gap_valid", inst_valid, 1);
    chk("t2_pc2_no_gap", inst_pc, 8'h02);

    // 3. Redirect with a buffered entry and a request in flight.
    do_reset();
    start = 1'b1; inst_ready = 1'b0;
    tick(); start = 1'b0;
    tick();
    tick(); #1;
    chk("t3_pre_valid", inst_valid, 1);
    chk("t3_pre_busy", busy, 1);
    redirect_valid = 1'b1; redirect_pc = 8'h40; #1;
    chk("t3_no_issue_redirect", rom_read, 0);
    tick(); redirect_valid = 1'b0; #1;
    chk("t3_flushed", inst_valid, 0);
    chk("t3_read40", rom_read, 1);
    chk("t3_addr40", rom_address, 8'h40);
    tick(); #1;
    chk("t3_inflight_dropped", inst_valid, 0);
    chk("t3_addr41", rom_address, 8'h41);
    tick(); inst_ready = 1'b1; #1;
    chk("t3_valid40", inst_valid, 1);
    chk("t3_pc40", inst_pc, 8'h40);
    chk("t3_data40", inst_data, memv(8'h40));
    tick(); #1;
    chk("t3_pc41", inst_pc, 8'h41);

    // 4. Redirect near the top of the address space: PC wraps.
    redirect_valid = 1'b1; redirect_pc = 8'hFE; #1;
    chk("t4_no_issue_redirect", rom_read, 0);
    tick(); redirect_valid = 1'b0; #1;
    chk("t4_addrFE", rom_address, 8'hFE);
    chk("t4_readFE", rom_read, 1);
    tick(); #1;
    chk("t4_addrFF", rom_address, 8'hFF);
    chk("t4_empty", inst_valid, 0);
    tick(); #1;
    chk("t4_pcFE", inst_pc, 8'hFE);
    tick(); #1;
    chk("t4_pcFF", inst_pc, 8'hFF);
    tick(); #1;
    chk("t4_pc00", inst_pc, 8'h00);
    chk("t4_data00", inst_data, memv(8'h00));
    tick(); #1;
    chk("t4_pc01", inst_pc, 8'h01);

    // 5. Halt at pc 5, drain, then resume at pc 5.
    do_reset();
    start = 1'b1; inst_ready = 1'b1;
    tick(); start = 1'b0;
    repeat (5) tick();
    #1;
    chk("t5_addr5", rom_address, 8'h05);
    halt_req = 1'b1; #1;
    chk("t5_halt_no_read", rom_read, 0);
    tick(); halt_req = 1'b0; #1;
    chk("t5_halted_no_read", rom_read, 0);
    chk("t5_drain_pc4", inst_pc, 8'h04);
    chk("t5_drain_busy", busy, 1);
    tick(); #1;
    chk("t5_drained_valid", inst_valid, 0);
    chk("t5_drained_busy", busy, 0);
    chk("t5_drained_no_read", rom_read, 0);
    start = 1'b1; #1;
    chk("t5_start_cycle_no_read", rom_read, 0);
    tick(); start = 1'b0; #1;
    chk("t5_resume_read", rom_read, 1);
    chk("t5_resume_addr", rom_address, 8'h05);
    tick();
    tick(); #1;
    chk("t5_resume_valid", inst_valid, 1);
    chk("t5_resume_pc", inst_pc, 8'h05);

    // 6. Reset one cycle after an issue: late ROM data is ignored.
    do_reset();
    start = 1'b1; inst_ready = 1'b1;
    tick(); start = 1'b0; #1;
    chk("t6_read0", rom_read, 1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("t6_valid_after_rst", inst_valid, 0);
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_no_read_after_rst", rom_read, 0);
    chk("t6_addr_after_rst", rom_address, 8'h00);
    tick(); #1;
    chk("t6_late_data_ignored", inst_valid, 0);
    chk("t6_busy_late", busy, 0);
`ifdef FETCH_STATS_EN
    chk("t6_fetch_count_zero", fetch_count, 0);
    chk("t6_stall_count_zero", stall_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
